// File: rtl/alien_bomb.sv
// Alien return fire: picks a live column, drops one bomb from its lowest alien,
// and detects a bomb/player collision that costs the player a life.
module alien_bomb #(
  parameter int Fire_Interval      = 40,
  parameter int Bomb_Speed         = 4,
  parameter int AlienWidth         = 30,
  parameter int AlienHeight        = 20,
  parameter int AlienWidthSpacing  = 10,
  parameter int AlienHeightSpacing = 10,
  parameter int PlayerWidth        = 30,
  parameter int PlayerHeight       = 20,
  parameter int BombWidth          = 10,
  parameter int BombHeight         = 20,
  parameter int Start_Lives        = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Tick,
  input  logic [49:0] Aliens_Grid,
  input  logic [8:0]  Aliens_Row,
  input  logic [9:0]  Aliens_Col,
  input  logic [8:0]  Player_Row,
  input  logic [9:0]  Player_Col,
  output logic [8:0]  Bomb_Row,
  output logic [9:0]  Bomb_Col,
  output logic        Bomb_Active,
  output logic        Player_Hit,
  output logic [1:0]  Lives,
  output logic        Game_Over,
  output logic [2:0]  State_Dbg
);

  localparam int CNT_W = (Fire_Interval > 2) ? $clog2(Fire_Interval) : 1;
  localparam logic [8:0] ROW_PARK = 9'd500;
  localparam logic [9:0] COL_PARK = 10'd350;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_PICK = 3'd1,
    ST_SCAN = 3'd2,
    ST_FALL = 3'd3,
    ST_HIT  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       c0_q, c0_d;
  logic [3:0]       idx_q;
  logic [8:0]       bomb_row_q;
  logic [9:0]       bomb_col_q;
  logic             active_q;
  logic             hit_q;
  logic [1:0]       lives_q;

  logic [4:0]  scan_sum;
  logic [3:0]  scan_col;
  logic        found;
  logic [2:0]  found_row;
  logic [9:0]  col_calc;
  logic [8:0]  row_calc;
  logic [9:0]  next_row;
  logic        collide;
  logic [10:0] b_col, b_row, p_col, p_row;

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign c0_d   = (lfsr_q[3:0] >= 4'd10) ? lfsr_q[3:0] - 4'd10 : lfsr_q[3:0];

  assign scan_sum = {1'b0, c0_q} + {1'b0, idx_q};
  assign scan_col = (scan_sum >= 5'd10) ? 4'(scan_sum - 5'd10) : scan_sum[3:0];

  // Ascending loop leaves the lowest (largest-row) live alien in the column.
  always_comb begin
    found     = 1'b0;
    found_row = 3'd0;
    for (int r = 0; r < 5; r++) begin
      if (Aliens_Grid[6'(r * 10) + {2'b00, scan_col}]) begin
        found     = 1'b1;
        found_row = 3'(r);
      end
    end
  end

  assign col_calc = Aliens_Col + 10'(scan_col) * 10'(AlienWidth + AlienWidthSpacing)
                  + 10'((AlienWidth - BombWidth) / 2);
  assign row_calc = Aliens_Row + 9'(found_row) * 9'(AlienHeight + AlienHeightSpacing)
                  + 9'(AlienHeight);
  assign next_row = {1'b0, bomb_row_q} + 10'(Bomb_Speed);

  assign b_col = {1'b0, bomb_col_q};
  assign b_row = {2'b00, bomb_row_q};
  assign p_col = {1'b0, Player_Col};
  assign p_row = {2'b00, Player_Row};
  assign collide = (b_col < p_col + 11'(PlayerWidth)) && (b_col + 11'(BombWidth) > p_col) &&
                   (b_row < p_row + 11'(PlayerHeight)) && (b_row + 11'(BombHeight) > p_row);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_WAIT;
      cnt_q      <= '0;
      lfsr_q     <= 16'hACE1;
      c0_q       <= 4'd0;
      idx_q      <= 4'd0;
      bomb_row_q <= ROW_PARK;
      bomb_col_q <= COL_PARK;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
      lives_q    <= 2'(Start_Lives);
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        ST_WAIT: begin
          if (Tick && !Game_Over) begin
            if (cnt_q == CNT_W'(Fire_Interval - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_PICK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_PICK: begin
          c0_q    <= c0_d;
          idx_q   <= 4'd0;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (found) begin
            bomb_col_q <= col_calc;
            bomb_row_q <= row_calc;
            active_q   <= 1'b1;
            state_q    <= ST_FALL;
          end else if (idx_q == 4'd9) begin
            state_q <= ST_WAIT;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        ST_FALL: begin
          // A hit wins over a same-cycle move.
          if (collide) begin
            hit_q      <= 1'b1;
            active_q   <= 1'b0;
            bomb_row_q <= ROW_PARK;
            lives_q    <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            state_q    <= ST_HIT;
          end else if (Tick) begin
            if (next_row >= 10'd480) begin
              active_q   <= 1'b0;
              bomb_row_q <= ROW_PARK;
              state_q    <= ST_WAIT;
            end else begin
              bomb_row_q <= next_row[8:0];
            end
          end
        end
        ST_HIT: begin
          hit_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign Bomb_Row    = bomb_row_q;
  assign Bomb_Col    = bomb_col_q;
  assign Bomb_Active = active_q;
  assign Player_Hit  = hit_q;
  assign Lives       = lives_q;
  assign Game_Over   = (lives_q == 2'd0);
  assign State_Dbg   = state_q;

endmodule

// File: tb/tb_alien_bomb.sv
// Directed bench for alien_bomb: launch position, fall, miss, hit, empty grid,
// game over and asynchronous reset during flight.
module tb_alien_bomb;

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_PICK = 3'd1;
  localparam logic [2:0] ST_SCAN = 3'd2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Tick = 1'b0;
  logic [49:0] Aliens_Grid = '0;
  logic [8:0]  Aliens_Row = '0;
  logic [9:0]  Aliens_Col = '0;
  logic [8:0]  Player_Row = '0;
  logic [9:0]  Player_Col = '0;
  logic [8:0]  Bomb_Row;
  logic [9:0]  Bomb_Col;
  logic        Bomb_Active;
  logic        Player_Hit;
  logic [1:0]  Lives;
  logic        Game_Over;
  logic [2:0]  State_Dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int hit_cnt  = 0;

  alien_bomb #(.Fire_Interval(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick),
    .Aliens_Grid(Aliens_Grid), .Aliens_Row(Aliens_Row), .Aliens_Col(Aliens_Col),
    .Player_Row(Player_Row), .Player_Col(Player_Col),
    .Bomb_Row(Bomb_Row), .Bomb_Col(Bomb_Col), .Bomb_Active(Bomb_Active),
    .Player_Hit(Player_Hit), .Lives(Lives), .Game_Over(Game_Over),
    .State_Dbg(State_Dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Player_Hit) hit_cnt++;

  // driver tasks
  task automatic tick_pulse();
    @(negedge Clk) Tick = 1'b1;
    @(negedge Clk) Tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge Clk) Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic launch(input logic [9:0] exp_col, input logic [8:0] exp_row);
    bit seen = 0;
    tick_pulse();
    tick_pulse();
    for (int i = 0; i < 12; i++) begin
      if (Bomb_Active) begin seen = 1; break; end
      @(negedge Clk);
    end
    n_checks++;
    if (!seen) $display("FAIL launch_timeout: Bomb_Active=%0b required 1", Bomb_Active);
    else n_pass++;
    n_checks++;
    if (Bomb_Col !== exp_col) $display("FAIL launch_col: got %0d required %0d", Bomb_Col, exp_col);
    else n_pass++;
    n_checks++;
    if (Bomb_Row !== exp_row) $display("FAIL launch_row: got %0d required %0d", Bomb_Row, exp_row);
    else n_pass++;
  endtask

  // Ticks the bomb down until it vanishes; returns last on-screen row.
  task automatic drop_until_gone(output logic [8:0] last_row);
    last_row = Bomb_Row;
    for (int i = 0; i < 100; i++) begin
      tick_pulse();
      if (!Bomb_Active) break;
      last_row = Bomb_Row;
    end
  endtask

  task automatic hit_once(input logic [1:0] exp_lives);
    logic [8:0] last_row;
    int h0;
    h0 = hit_cnt;
    launch(10'd310, 9'd190);
    drop_until_gone(last_row);
    n_checks++;
    if (last_row !== 9'd382) $display("FAIL hit_row: got %0d required 382", last_row);
    else n_pass++;
    n_checks++;
    if (hit_cnt - h0 !== 1) $display("FAIL hit_pulses: got %0d required 1", hit_cnt - h0);
    else n_pass++;
    n_checks++;
    if (Lives !== exp_lives) $display("FAIL hit_lives: got %0d required %0d", Lives, exp_lives);
    else n_pass++;
    n_checks++;
    if (Bomb_Active !== 1'b0 || Bomb_Row !== 9'd500)
      $display("FAIL hit_clear: active=%0b row=%0d required 0/500", Bomb_Active, Bomb_Row);
    else n_pass++;
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (Bomb_Active !== 1'b0 || Bomb_Row !== 9'd500 || Bomb_Col !== 10'd350)
      $display("FAIL reset_bomb: active=%0b row=%0d col=%0d required 0/500/350",
               Bomb_Active, Bomb_Row, Bomb_Col);
    else n_pass++;
    n_checks++;
    if (Lives !== 2'd3 || Game_Over !== 1'b0 || Player_Hit !== 1'b0)
      $display("FAIL reset_status: lives=%0d go=%0b hit=%0b required 3/0/0",
               Lives, Game_Over, Player_Hit);
    else n_pass++;
    n_checks++;
    if (State_Dbg !== ST_WAIT) $display("FAIL reset_state: got %0d required %0d", State_Dbg, ST_WAIT);
    else n_pass++;
    Reset_n = 1'b1;
  endtask

  task automatic test_launch();
    Aliens_Grid = 50'h1 << 47;
    Aliens_Row  = 9'd50;
    Aliens_Col  = 10'd20;
    Player_Row  = 9'd400;
    Player_Col  = 10'd0;
    launch(10'd310, 9'd190);
  endtask

  task automatic test_fall_miss();
    logic [9:0] exp_row;
    int h0, bad;
    h0 = hit_cnt;
    bad = 0;
    exp_row = 10'd190;
    for (int i = 0; i < 100; i++) begin
      tick_pulse();
      exp_row = exp_row + 10'd4;
      if (exp_row >= 10'd480) break;
      if (Bomb_Row !== exp_row[8:0] || Bomb_Active !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL fall_step: %0d tick steps off, required 0", bad);
    else n_pass++;
    n_checks++;
    if (Bomb_Active !== 1'b0 || Bomb_Row !== 9'd500)
      $display("FAIL fall_exit: active=%0b row=%0d required 0/500", Bomb_Active, Bomb_Row);
    else n_pass++;
    n_checks++;
    if (State_Dbg !== ST_WAIT || hit_cnt != h0)
      $display("FAIL fall_wait: state=%0d hits=%0d required %0d/0", State_Dbg, hit_cnt - h0, ST_WAIT);
    else n_pass++;
  endtask

  task automatic test_hit();
    Player_Col = 10'd300;
    hit_once(2'd2);
    n_checks++;
    if (State_Dbg !== ST_WAIT || Game_Over !== 1'b0)
      $display("FAIL hit_state: state=%0d go=%0b required %0d/0", State_Dbg, Game_Over, ST_WAIT);
    else n_pass++;
  endtask

  task automatic test_empty_grid();
    int scans, act;
    Aliens_Grid = '0;
    scans = 0;
    act = 0;
    tick_pulse();
    tick_pulse();
    n_checks++;
    if (State_Dbg !== ST_PICK) $display("FAIL empty_pick: state=%0d required %0d", State_Dbg, ST_PICK);
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      if (State_Dbg === ST_SCAN) scans++;
      if (Bomb_Active) act++;
    end
    n_checks++;
    if (scans != 10) $display("FAIL empty_scan_cycles: got %0d required 10", scans);
    else n_pass++;
    n_checks++;
    if (act != 0 || State_Dbg !== ST_WAIT)
      $display("FAIL empty_result: active_cycles=%0d state=%0d required 0/%0d", act, State_Dbg, ST_WAIT);
    else n_pass++;
  endtask

  task automatic test_game_over();
    int launches;
    Aliens_Grid = 50'h1 << 47;
    hit_once(2'd1);
    hit_once(2'd0);
    n_checks++;
    if (Game_Over !== 1'b1) $display("FAIL game_over: got %0b required 1", Game_Over);
    else n_pass++;
    launches = 0;
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      repeat (3) @(negedge Clk);
      if (Bomb_Active || State_Dbg !== ST_WAIT) launches++;
    end
    n_checks++;
    if (launches != 0) $display("FAIL game_over_quiet: %0d launch samples required 0", launches);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fall();
    apply_reset();
    n_checks++;
    if (Lives !== 2'd3) $display("FAIL reload_lives: got %0d required 3", Lives);
    else n_pass++;
    // Column 2 with aliens in rows 0 and 3; the bomb must come from row 3.
    Aliens_Grid = (50'h1 << 2) | (50'h1 << 32);
    Aliens_Row  = 9'd100;
    Aliens_Col  = 10'd0;
    Player_Col  = 10'd0;
    launch(10'd90, 9'd210);
    Aliens_Grid = '0;
    repeat (3) tick_pulse();
    n_checks++;
    if (Bomb_Active !== 1'b1 || Bomb_Row !== 9'd222)
      $display("FAIL grid_independent: active=%0b row=%0d required 1/222", Bomb_Active, Bomb_Row);
    else n_pass++;
    @(negedge Clk) Reset_n = 1'b0;
    #1;
    n_checks++;
    if (Bomb_Active !== 1'b0 || Bomb_Row !== 9'd500 || Lives !== 2'd3 || State_Dbg !== ST_WAIT)
      $display("FAIL async_reset: active=%0b row=%0d lives=%0d state=%0d required 0/500/3/%0d",
               Bomb_Active, Bomb_Row, Lives, State_Dbg, ST_WAIT);
    else n_pass++;
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_fall_miss();
    test_hit();
    test_empty_grid();
    test_game_over();
    test_reset_mid_fall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
